// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller driving both ports of an external registered-read
// dual-port RAM. Words are prefetched into a 2-entry output buffer so the read side
// is show-ahead and both sides can move one word per cycle.

module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W+1:0] o_count,
  output logic              o_ram_wren,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic [ADDR_W-1:0] o_ram_raddr,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int CNT_W = ADDR_W + 2;

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;    // head of the output buffer
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              rdy_q, rdy_d;      // holds o_wr_ready low until the first clock after reset

  logic [PTR_W-1:0]  ram_cnt;
  logic              full;
  logic              push;
  logic              pop;
  logic              fetch;
  logic [1:0]        keep_cnt;          // buffer entries left after this cycle's pop
  logic [2:0]        occ;               // buffer + in-flight words after this cycle's pop

  // Handshakes, fetch decision and next-state computation for pointers and buffer.
  always_comb begin
    ram_cnt     = wptr_q - rptr_q;
    full        = (ram_cnt == PTR_W'(DEPTH));
    o_wr_ready  = rdy_q & ~full;
    push        = i_wr_valid & o_wr_ready;
    o_rd_valid  = (buf_cnt_q != 2'd0);
    o_rd_data   = buf0_q;
    pop         = o_rd_valid & i_rd_ready;
    keep_cnt    = buf_cnt_q - {1'b0, pop};
    occ         = {1'b0, keep_cnt} + {2'b00, inflight_q};
    // Only fetch when the landing slot is guaranteed free next edge.
    fetch       = (ram_cnt != {PTR_W{1'b0}}) & (occ < 3'd2);

    o_ram_wren  = push;
    o_ram_waddr = wptr_q[ADDR_W-1:0];
    o_ram_wdata = i_wr_data;
    o_ram_raddr = rptr_q[ADDR_W-1:0];
    o_count     = CNT_W'(ram_cnt) + CNT_W'(inflight_q) + CNT_W'(buf_cnt_q);

    rdy_d      = 1'b1;
    inflight_d = fetch;

    if (push) begin
      wptr_d = wptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end

    if (fetch) begin
      rptr_d = rptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end

    // Pop shifts the second entry to the head; a landing word then goes to the first free slot.
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
    end else begin
      buf0_d = buf0_q;
    end

    if (inflight_q) begin
      case (keep_cnt)
        2'd0:    buf0_d = i_ram_rdata;
        2'd1:    buf1_d = i_ram_rdata;
        default: buf1_d = buf1_q;       // unreachable by the fetch rule; flagged by the checker
      endcase
    end else begin
      buf1_d = buf1_d;
    end

    buf_cnt_d = keep_cnt + {1'b0, inflight_q};
  end

  // State registers with asynchronous reset that discards every stored word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= {PTR_W{1'b0}};
      rptr_q     <= {PTR_W{1'b0}};
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= {DATA_W{1'b0}};
      buf1_q     <= {DATA_W{1'b0}};
      rdy_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      rdy_q      <= rdy_d;
    end
  end

  ram_fifo_ctrl_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .inflight (inflight_q),
    .buf_cnt  (buf_cnt_q),
    .pop      (pop),
    .wren     (o_ram_wren),
    .full     (full)
  );

endmodule

// Invariant checker for the controller's internal state.
module ram_fifo_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       inflight,
  input logic [1:0] buf_cnt,
  input logic       pop,
  input logic       wren,
  input logic       full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(inflight && (buf_cnt == 2'd2) && !pop))
    else $error("landing into a full output buffer");

  a_no_write_full: assert property (@(posedge clk) disable iff (rst)
    !(wren && full))
    else $error("RAM write while full");

  a_buf_cnt_range: assert property (@(posedge clk) disable iff (rst)
    (buf_cnt != 2'd3))
    else $error("output buffer count out of range");

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: directed scenarios plus random traffic, all compared
// every cycle against a queue model of the FIFO.

module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [DW-1:0] i_wr_data;
  logic          o_rd_valid;
  logic          i_rd_ready;
  logic [DW-1:0] o_rd_data;
  logic [AW+1:0] o_count;
  logic          ram_wren;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:DEPTH-1];

  int nvec = 0;
  int nmis = 0;

  // model state: q holds every word in the FIFO, oldest first;
  // the last ram_n entries are still in RAM, pend of the ones before them are in flight
  logic [DW-1:0] q [$];
  int ram_n = 0;
  int pend = 0;
  int push_cnt = 0;
  int fetch_cnt = 0;
  bit rdy_m = 1'b0;
  int dut_pops = 0;
  int ready_low = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wr_valid  (i_wr_valid),
    .o_wr_ready  (o_wr_ready),
    .i_wr_data   (i_wr_data),
    .o_rd_valid  (o_rd_valid),
    .i_rd_ready  (i_rd_ready),
    .o_rd_data   (o_rd_data),
    .o_count     (o_count),
    .o_ram_wren  (ram_wren),
    .o_ram_waddr (ram_waddr),
    .o_ram_wdata (ram_wdata),
    .o_ram_raddr (ram_raddr),
    .i_ram_rdata (ram_rdata)
  );

  // registered-read dual-port RAM
  always @(posedge clk) begin
    if (ram_wren) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, then advance the model over the coming edge
  always @(negedge clk) begin
    int  vis;
    bit  e_rdy;
    bit  e_push;
    bit  e_pop;
    bit  e_fetch;
    if (rst) begin
      chk("rst_valid", o_rd_valid, 0);
      chk("rst_count", o_count, 0);
      chk("rst_wr_ready", o_wr_ready, 0);
      chk("rst_data", o_rd_data, 0);
      q.delete();
      ram_n = 0; pend = 0; push_cnt = 0; fetch_cnt = 0; rdy_m = 1'b0;
    end else begin
      vis     = q.size() - ram_n - pend;
      e_rdy   = rdy_m && (ram_n < DEPTH);
      e_push  = i_wr_valid && e_rdy;
      e_pop   = i_rd_ready && (vis > 0);
      e_fetch = (ram_n > 0) && ((q.size() - ram_n - (e_pop ? 1 : 0)) < 2);

      chk("wr_ready", o_wr_ready, e_rdy);
      chk("rd_valid", o_rd_valid, vis > 0);
      chk("count", o_count, q.size());
      if (vis > 0) chk("rd_data", o_rd_data, q[0]);
      chk("ram_wren", ram_wren, e_push);
      if (e_push) begin
        chk("ram_waddr", ram_waddr, push_cnt % DEPTH);
        chk("ram_wdata", ram_wdata, i_wr_data);
      end
      chk("ram_raddr", ram_raddr, fetch_cnt % DEPTH);

      if (o_rd_valid && i_rd_ready) dut_pops++;
      if (!o_wr_ready) ready_low++;

      if (e_pop) void'(q.pop_front());
      if (e_fetch) fetch_cnt++;
      ram_n = ram_n - (e_fetch ? 1 : 0) + (e_push ? 1 : 0);
      pend  = e_fetch ? 1 : 0;
      if (e_push) begin
        q.push_back(i_wr_data);
        push_cnt++;
      end
      rdy_m = 1'b1;
    end
  end

  task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit rr);
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && o_count != 0; k++) drive(1'b0, 8'h00, 1'b1);
    chk("drain_empty", o_count, 0);
  endtask

  initial begin
    int p0;
    int r0;
    rst = 1'b1;
    i_wr_valid = 1'b0;
    i_wr_data  = 8'h00;
    i_rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("t1_ready_after_rst", o_wr_ready, 1);

    // 1: single word latency
    drive(1'b1, 8'hA5, 1'b1);
    chk("t1_valid_e0", o_rd_valid, 0);
    chk("t1_count_e0", o_count, 1);
    drive(1'b0, 8'h00, 1'b1);
    chk("t1_valid_e1", o_rd_valid, 0);
    drive(1'b0, 8'h00, 1'b1);
    chk("t1_valid_e2", o_rd_valid, 1);
    chk("t1_data_e2", o_rd_data, 8'hA5);
    chk("t1_count_e2", o_count, 1);
    drive(1'b0, 8'h00, 1'b1);
    chk("t1_count_e3", o_count, 0);
    chk("t1_valid_e3", o_rd_valid, 0);

    // 2: fill to capacity, stall, free one slot
    for (int i = 1; i <= 10; i++) drive(1'b1, 8'(i), 1'b0);
    chk("t2_count_full", o_count, 10);
    chk("t2_ready_full", o_wr_ready, 0);
    repeat (3) drive(1'b1, 8'h0B, 1'b0);
    chk("t2_count_stall", o_count, 10);
    chk("t2_head", o_rd_data, 8'h01);
    drive(1'b1, 8'h0B, 1'b1);
    chk("t2_count_pop", o_count, 9);
    chk("t2_ready_back", o_wr_ready, 1);
    drive(1'b1, 8'h0B, 1'b0);
    chk("t2_count_refill", o_count, 10);
    chk("t2_ready_refull", o_wr_ready, 0);
    drain();

    // 3: streaming, one in and one out per cycle
    p0 = dut_pops;
    r0 = ready_low;
    for (int i = 0; i < 64; i++) drive(1'b1, 8'(i), 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b1);
    chk("t3_pops", dut_pops - p0, 64);
    chk("t3_ready_drops", ready_low - r0, 0);
    chk("t3_count", o_count, 0);

    // 6: pop coincides with a landing
    drive(1'b1, 8'hC1, 1'b0);
    drive(1'b1, 8'hC2, 1'b0);
    drive(1'b1, 8'hC3, 1'b0);
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    chk("t6_count3", o_count, 3);
    chk("t6_head1", o_rd_data, 8'hC1);
    drive(1'b0, 8'h00, 1'b1);
    chk("t6_count2", o_count, 2);
    chk("t6_head2", o_rd_data, 8'hC2);
    drive(1'b0, 8'h00, 1'b1);
    chk("t6_count1", o_count, 1);
    chk("t6_head3", o_rd_data, 8'hC3);
    chk("t6_valid3", o_rd_valid, 1);
    drive(1'b0, 8'h00, 1'b1);
    chk("t6_count0", o_count, 0);

    // 5: reset mid-stream
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_valid_rst", o_rd_valid, 0);
    chk("t5_count_rst", o_count, 0);
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    chk("t5_ready", o_wr_ready, 1);
    drive(1'b1, 8'h77, 1'b0);
    for (int k = 0; k < 6 && !o_rd_valid; k++) drive(1'b0, 8'h00, 1'b0);
    chk("t5_valid", o_rd_valid, 1);
    chk("t5_data", o_rd_data, 8'h77);
    chk("t5_count", o_count, 1);
    drain();

    // 4: random traffic
    for (int k = 0; k < 2000; k++)
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
